// File: rtl/regfile_pkg.sv
// regfile_pkg: constants and types shared by the register file slice.
// Provides DATA_W/NUM_REGS/ZERO_REG, reg_idx_t / reg_word_t and a
// popcount helper that is used to classify the decoder's write-enable vector.
package regfile_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ZERO_REG = 31;

    typedef logic [4:0]        reg_idx_t;
    typedef logic [DATA_W-1:0] reg_word_t;

    // Number of set bits in a NUM_REGS-wide enable vector.
    function automatic logic [5:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + {5'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_array_if.sv
// regfile_array_if: write/read bus of the register file array.
//   decoded        one-hot write enable from the 5-to-32 decoder
//   WriteData      data for the enabled register
//   ReadRegister1/2 read indices, ReadData1/2 read data
//   multi_hot_err  sticky multi-hot indication
// master = the side driving writes/read indices, slave = the array.
interface regfile_array_if;
    import regfile_pkg::*;

    logic [NUM_REGS-1:0] decoded;
    reg_word_t           WriteData;
    reg_idx_t            ReadRegister1;
    reg_idx_t            ReadRegister2;
    reg_word_t           ReadData1;
    reg_word_t           ReadData2;
    logic                multi_hot_err;

    modport master (
        output decoded, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2, multi_hot_err
    );

    modport slave (
        input  decoded, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2, multi_hot_err
    );

endinterface

// File: rtl/regfile_word.sv
// regfile_word: one DATA_W-wide storage register.
//   clk    rising-edge clock
//   reset  synchronous active-high clear (has priority over we)
//   we     write enable
//   d      write data
//   q      stored value
module regfile_word
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      we,
    input  reg_word_t d,
    output reg_word_t q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_array.sv
// regfile_array: 32 x DATA_W register file storage array.
//   clk    rising-edge clock
//   reset  synchronous active-high; clears all registers and the error flag,
//          and drops any write presented in the same cycle
//   bus    regfile_array_if.slave: decoded write enable, WriteData,
//          two read ports, sticky multi_hot_err
// Register ZERO_REG has no storage: it reads as zero and ignores writes.
// A multi-hot decoded vector suppresses the whole write and sets the
// sticky error flag until the next reset.
// Optional build macro: REGFILE_BYPASS_EN forwards WriteData to a read port
// that addresses the register being written in the same cycle.
module regfile_array
    import regfile_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    regfile_array_if.slave bus
);

    logic [5:0] hot_cnt;
    logic       single_hot;
    logic       multi_hot;
    logic       err_q;
    reg_word_t  word_q [NUM_REGS];
    reg_word_t  rd1;
    reg_word_t  rd2;

    always_comb begin
        hot_cnt    = popcount(bus.decoded);
        single_hot = (hot_cnt == 6'd1);
        multi_hot  = (hot_cnt > 6'd1);
    end

    // Storage: one regfile_word per register except ZERO_REG, which is tied off.
    // Only a single-hot vector enables a word, so multi-hot writes hit nothing.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign word_q[i] = '0;
        end else begin : g_word
            regfile_word u_word (
                .clk   (clk),
                .reset (reset),
                .we    (single_hot & bus.decoded[i]),
                .d     (bus.WriteData),
                .q     (word_q[i])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (multi_hot) begin
            err_q <= 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;

    // Forward only a write that will actually commit at the next edge.
    always_comb begin
        hit1 = single_hot & ~reset & bus.decoded[bus.ReadRegister1]
               & (bus.ReadRegister1 != reg_idx_t'(ZERO_REG));
        hit2 = single_hot & ~reset & bus.decoded[bus.ReadRegister2]
               & (bus.ReadRegister2 != reg_idx_t'(ZERO_REG));
        rd1  = hit1 ? bus.WriteData : word_q[bus.ReadRegister1];
        rd2  = hit2 ? bus.WriteData : word_q[bus.ReadRegister2];
    end
`else
    always_comb begin
        rd1 = word_q[bus.ReadRegister1];
        rd2 = word_q[bus.ReadRegister2];
    end
`endif

    assign bus.ReadData1     = rd1;
    assign bus.ReadData2     = rd2;
    assign bus.multi_hot_err = err_q;

endmodule

// File: tb/tb_regfile_array.sv
// tb_regfile_array: directed plus randomized checks of regfile_array against
// an array-based reference model. Honours REGFILE_BYPASS_EN the same way as
// the design build.
module tb_regfile_array;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fails  = 0;

    logic [63:0] mem [32];
    logic        err_m;

    regfile_array_if bus ();

    regfile_array dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value from the model, applying the spec's read rules.
    function automatic logic [63:0] exp_read(input logic [4:0] idx, input logic rst_i,
                                             input logic [31:0] dec, input logic [63:0] wd);
        logic [63:0] v;
        v = (idx == 5'd31) ? 64'd0 : mem[idx];
`ifdef REGFILE_BYPASS_EN
        if (!rst_i && $countones(dec) == 1 && dec[idx] && idx != 5'd31) v = wd;
`endif
        return v;
    endfunction

    // One cycle: drive at negedge, check reads/flag combinationally,
    // cross the rising edge, then advance the model.
    task automatic step(input logic rst_i, input logic [31:0] dec, input logic [63:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
        reset             = rst_i;
        bus.decoded       = dec;
        bus.WriteData     = wd;
        bus.ReadRegister1 = r1;
        bus.ReadRegister2 = r2;
        #1;
        check($sformatf("rd1[%0d]", r1), bus.ReadData1, exp_read(r1, rst_i, dec, wd));
        check($sformatf("rd2[%0d]", r2), bus.ReadData2, exp_read(r2, rst_i, dec, wd));
        check("multi_hot_err", {63'd0, bus.multi_hot_err}, {63'd0, err_m});
        @(posedge clk);
        if (rst_i) begin
            for (int unsigned i = 0; i < 32; i++) mem[i] = '0;
            err_m = 1'b0;
        end else if ($countones(dec) == 1) begin
            for (int unsigned i = 0; i < 31; i++) if (dec[i]) mem[i] = wd;
        end else if ($countones(dec) >= 2) begin
            err_m = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] dec;
        int unsigned sel;

        reset             = 1'b1;
        bus.decoded       = '0;
        bus.WriteData     = '0;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int unsigned i = 0; i < 32; i++) mem[i] = '0;
        err_m = 1'b0;

        // 1: every index reads zero after reset
        for (int unsigned i = 0; i < 32; i++)
            step(1'b0, 32'h0, 64'h0, 5'(i), 5'(31 - i));

        // 2: single write to reg 3, visible next cycle; neighbours untouched
        step(1'b0, 32'h0000_0008, 64'hDEAD_BEEF_0000_0003, 5'd0, 5'd3);
        step(1'b0, 32'h0, 64'h0, 5'd3, 5'd2);
        step(1'b0, 32'h0, 64'h0, 5'd4, 5'd3);

        // 3: writes to the zero register are ignored and not an error
        step(1'b0, 32'h8000_0000, '1, 5'd31, 5'd31);
        step(1'b0, 32'h0, 64'h0, 5'd31, 5'd3);

        // 4: multi-hot suppresses the write, sets a sticky flag cleared by reset
        step(1'b0, 32'h0000_0006, 64'h5, 5'd1, 5'd2);
        for (int unsigned i = 0; i < 10; i++)
            step(1'b0, 32'h0, 64'h0, 5'd1, 5'd2);
        step(1'b1, 32'h0, 64'h0, 5'd3, 5'd1);
        step(1'b0, 32'h0, 64'h0, 5'd3, 5'd1);

        // 5: read of a register in the cycle it is written
        step(1'b0, 32'h0000_0010, 64'hAA, 5'd0, 5'd4);
        step(1'b0, 32'h0, 64'h0, 5'd0, 5'd4);

        // 6: reset beats a simultaneous write
        step(1'b0, 32'h0000_0020, 64'h77, 5'd5, 5'd4);
        step(1'b1, 32'h0000_0020, 64'h99, 5'd5, 5'd4);
        step(1'b0, 32'h0, 64'h0, 5'd5, 5'd4);

        // Random traffic
        for (int unsigned n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 55)      dec = 32'h1 << $urandom_range(0, 30);
            else if (sel < 70) dec = 32'h0;
            else if (sel < 78) dec = 32'h8000_0000;
            else if (sel < 86) dec = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
            else begin
                // Reads aimed at a register written this cycle
                dec = 32'h1 << $urandom_range(0, 31);
            end
            step(($urandom_range(0, 99) < 4), dec, {$urandom, $urandom},
                 (sel >= 86) ? 5'($clog2(dec)) : 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
